// File: rtl/decode_ctrl.sv
// Decode stage front end: one output entry plus one skid entry between fetch and
// execute, with load-use stall detection and an immediate generator on the output.

module imm_gen (
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);
  logic [6:0] w_opcode;
  assign w_opcode = i_inst[6:0];

  always_comb begin
    o_imm = '0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111:
        o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      7'b0100011:
        o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      7'b1100011:
        o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        o_imm = {i_inst[31:12], 12'b0};
      7'b1101111:
        o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default:
        o_imm = '0;
    endcase
  end
endmodule

module decode_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_imm,
  input  logic        id_ready,
  input  logic        flush,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  output logic [15:0] bubble_cnt
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and if_ready depends only on registered state.

  logic        r_out_valid;
  logic [31:0] r_out_inst;
  logic [31:0] r_out_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_inst;
  logic [31:0] r_skid_pc;
  logic [15:0] r_bubble_cnt;

  logic        w_accept;
  logic        w_consume;
  logic        w_hazard;
  logic        w_is_uj;
  logic        w_rs_match;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_opcode;

  assign w_opcode   = r_out_inst[6:0];
  assign w_rs1      = r_out_inst[19:15];
  assign w_rs2      = r_out_inst[24:20];
  // U and J formats carry immediate bits in the rs fields, so they never stall.
  assign w_is_uj    = (w_opcode == 7'b0110111) || (w_opcode == 7'b0010111) ||
                      (w_opcode == 7'b1101111);
  assign w_rs_match = (w_rs1 == ex_rd) || (w_rs2 == ex_rd);
  assign w_hazard   = r_out_valid && ex_load && (ex_rd != 5'd0) && !w_is_uj && w_rs_match;

  assign if_ready   = !r_skid_valid;
  assign id_valid   = r_out_valid && !w_hazard;
  assign id_inst    = r_out_inst;
  assign id_pc      = r_out_pc;
  assign bubble_cnt = r_bubble_cnt;

  assign w_accept   = if_valid && !r_skid_valid;
  assign w_consume  = id_valid && id_ready;

  imm_gen u_imm_gen (
    .i_inst (r_out_inst),
    .o_imm  (id_imm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_inst   <= '0;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_inst  <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_consume) begin
      if (r_skid_valid) begin
        r_out_inst   <= r_skid_inst;
        r_out_pc     <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_inst   <= if_inst;
        r_out_pc     <= if_pc;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      // Output entry still occupied (stalled or not consumed): park in the skid entry.
      if (r_out_valid) begin
        r_skid_inst  <= if_inst;
        r_skid_pc    <= if_pc;
        r_skid_valid <= 1'b1;
      end else begin
        r_out_inst   <= if_inst;
        r_out_pc     <= if_pc;
        r_out_valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_hazard && !flush && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end
endmodule
